// File: rtl/sopc_onchip_mem_arb.sv
// Two-master arbiter in front of a single-port on-chip RAM.
// Alternating-priority grants, one-cycle read return, out-of-range screening
// and saturating per-master grant counters.
module sopc_onchip_mem_arb #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DEPTH  = 10750
) (
    input  logic              clk,
    input  logic              reset_n,
    // master 0
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    // master 1
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    // RAM port
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    // status
    output logic [15:0]       m0_grant_cnt,
    output logic [15:0]       m1_grant_cnt,
    output logic              oor_err
);

    localparam int unsigned CNT_W = 16;
    // One extra bit so DEPTH never truncates against the address width.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic              req0, req1;
    logic              gnt0, gnt1, any_gnt;
    logic [ADDR_W-1:0] g_addr;
    logic [3:0]        g_be;
    logic [31:0]       g_wd;
    logic              g_wr;
    logic              in_range;

    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tag_vld_q, tag_vld_d;
    logic              tag_id_q, tag_id_d;
    logic              tag_oor_q, tag_oor_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic              oor_q, oor_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant decision: lone requester wins, contention goes to the master not granted last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            if (req0 && req1) begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Granted-master request mux and range check.
    always_comb begin
        any_gnt  = gnt0 | gnt1;
        g_addr   = gnt1 ? m1_address    : m0_address;
        g_be     = gnt1 ? m1_byteenable : m0_byteenable;
        g_wd     = gnt1 ? m1_writedata  : m0_writedata;
        g_wr     = gnt1 ? m1_write      : m0_write;
        in_range = {1'b0, g_addr} < DEPTH_X;
    end

    // Master handshake and RAM-side strobes.
    always_comb begin
        m0_waitrequest = ~reset_n | (req0 & ~gnt0);
        m1_waitrequest = ~reset_n | (req1 & ~gnt1);
        mem_address    = any_gnt ? g_addr : addr_q;
        mem_byteenable = g_be;
        mem_writedata  = g_wd;
        mem_chipselect = any_gnt;
        mem_write      = any_gnt & g_wr & in_range;
        mem_clken      = reset_n;
    end

    // Read return steered by the pending-read tag; zero when not valid or out of range.
    always_comb begin
        m0_readdatavalid = tag_vld_q & ~tag_id_q;
        m1_readdatavalid = tag_vld_q &  tag_id_q;
        m0_readdata      = (m0_readdatavalid && !tag_oor_q) ? mem_readdata : 32'h0;
        m1_readdata      = (m1_readdatavalid && !tag_oor_q) ? mem_readdata : 32'h0;
        m0_grant_cnt     = cnt0_q;
        m1_grant_cnt     = cnt1_q;
        oor_err          = oor_q;
    end

    // Next-state for priority, held address, read tag, counters and sticky error.
    always_comb begin
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        tag_vld_d    = 1'b0;
        tag_id_d     = tag_id_q;
        tag_oor_d    = tag_oor_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        oor_d        = oor_q;
        if (any_gnt) begin
            last_grant_d = gnt1;
            addr_d       = g_addr;
            tag_vld_d    = ~g_wr;
            tag_id_d     = gnt1;
            tag_oor_d    = ~in_range;
            if (!in_range) oor_d = 1'b1;
        end
        if (gnt0 && cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_W'(1);
        if (gnt1 && cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_W'(1);
    end

    // State registers; reset discards any pending read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            tag_vld_q    <= 1'b0;
            tag_id_q     <= 1'b0;
            tag_oor_q    <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            oor_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            tag_oor_q    <= tag_oor_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            oor_q        <= oor_d;
        end
    end

endmodule

// File: tb/tb_sopc_onchip_mem_arb.sv
// Directed bench for sopc_onchip_mem_arb with a behavioural RAM behind the memory port.
module tb_sopc_onchip_mem_arb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] m0_address = '0, m1_address = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [13:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [15:0] m0_grant_cnt, m1_grant_cnt;
    logic        oor_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sopc_onchip_mem_arb dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt), .oor_err(oor_err)
    );

    // Behavioural single-port RAM, one-cycle read latency, preloaded with A000_0000 | addr.
    logic [31:0] ram [0:16383];
    logic [31:0] ram_rd = '0;
    initial for (int i = 0; i < 16384; i++) ram[i] = 32'hA000_0000 | 32'(i);
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            ram_rd <= ram[mem_address];
        end
    end
    assign mem_readdata = ram_rd;

    typedef struct {
        string       nm;
        logic        r0, w0;
        logic [13:0] a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [13:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic        ew0, ew1, erv0, erv1;
        logic [31:0] erd0, erd1;
        logic        ecs, ewe;
        logic [13:0] eaddr;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm,
        input logic r0, input logic w0, input logic [13:0] a0, input logic [3:0] be0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [13:0] a1, input logic [3:0] be1, input logic [31:0] d1,
        input logic ew0, input logic ew1, input logic erv0, input logic [31:0] erd0,
        input logic erv1, input logic [31:0] erd1, input logic ecs, input logic ewe, input logic [13:0] eaddr);
        vec_t v;
        v.nm = nm; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.ew0 = ew0; v.ew1 = ew1; v.erv0 = erv0; v.erd0 = erd0; v.erv1 = erv1; v.erd1 = erd1;
        v.ecs = ecs; v.ewe = ewe; v.eaddr = eaddr;
        return v;
    endfunction

    // Drive each row at the falling edge, check the settled outputs before the next rising edge.
    task automatic run_vecs();
        foreach (vq[k]) begin
            @(negedge clk);
            m0_read = vq[k].r0; m0_write = vq[k].w0; m0_address = vq[k].a0;
            m0_byteenable = vq[k].be0; m0_writedata = vq[k].d0;
            m1_read = vq[k].r1; m1_write = vq[k].w1; m1_address = vq[k].a1;
            m1_byteenable = vq[k].be1; m1_writedata = vq[k].d1;
            #1;
            chk({vq[k].nm, ".wait0"}, 32'(m0_waitrequest), 32'(vq[k].ew0));
            chk({vq[k].nm, ".wait1"}, 32'(m1_waitrequest), 32'(vq[k].ew1));
            chk({vq[k].nm, ".rdv0"}, 32'(m0_readdatavalid), 32'(vq[k].erv0));
            chk({vq[k].nm, ".rd0"}, m0_readdata, vq[k].erd0);
            chk({vq[k].nm, ".rdv1"}, 32'(m1_readdatavalid), 32'(vq[k].erv1));
            chk({vq[k].nm, ".rd1"}, m1_readdata, vq[k].erd1);
            chk({vq[k].nm, ".cs"}, 32'(mem_chipselect), 32'(vq[k].ecs));
            chk({vq[k].nm, ".we"}, 32'(mem_write), 32'(vq[k].ewe));
            chk({vq[k].nm, ".addr"}, 32'(mem_address), 32'(vq[k].eaddr));
        end
        vq.delete();
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = '0; m1_address = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset state with both masters requesting.
        m0_read = 1; m1_read = 1; m0_address = 14'd7; m1_address = 14'd9;
        #3;
        chk("rst.wait0", 32'(m0_waitrequest), 32'd1);
        chk("rst.wait1", 32'(m1_waitrequest), 32'd1);
        chk("rst.cs", 32'(mem_chipselect), 32'd0);
        chk("rst.clken", 32'(mem_clken), 32'd0);
        chk("rst.addr", 32'(mem_address), 32'd0);
        chk("rst.rdv0", 32'(m0_readdatavalid), 32'd0);
        chk("rst.cnt0", 32'(m0_grant_cnt), 32'd0);
        chk("rst.oor", 32'(oor_err), 32'd0);
        do_reset();

        // Single write then read, plus read+write collapsing to a write.
        vq.push_back(mk("A0", 0,1,14'd5,4'hF,32'hDEADBEEF, 0,0,0,0,0, 0,0,0,0,0,0, 1,1,14'd5));
        vq.push_back(mk("A1", 1,0,14'd5,4'hF,0,            0,0,0,0,0, 0,0,0,0,0,0, 1,0,14'd5));
        vq.push_back(mk("A2", 0,0,14'd5,4'hF,0,            0,0,0,0,0, 0,0,1,32'hDEADBEEF,0,0, 0,0,14'd5));
        run_vecs();
        chk("A.cnt0", 32'(m0_grant_cnt), 32'd2);
        chk("A.clken", 32'(mem_clken), 32'd1);
        vq.push_back(mk("A3", 1,1,14'd3,4'hF,32'h12345678, 0,0,0,0,0, 0,0,0,0,0,0, 1,1,14'd3));
        vq.push_back(mk("A4", 1,0,14'd3,4'hF,0,            0,0,0,0,0, 0,0,0,0,0,0, 1,0,14'd3));
        vq.push_back(mk("A5", 0,0,14'd3,4'hF,0,            0,0,0,0,0, 0,0,1,32'h12345678,0,0, 0,0,14'd3));
        run_vecs();

        // Contention after reset: master 0 first, then strict alternation.
        do_reset();
        vq.push_back(mk("B0", 1,0,14'd1,0,0, 1,0,14'd2,0,0, 0,1,0,0,0,0, 1,0,14'd1));
        vq.push_back(mk("B1", 1,0,14'd1,0,0, 1,0,14'd2,0,0, 1,0,1,32'hA0000001,0,0, 1,0,14'd2));
        vq.push_back(mk("B2", 1,0,14'd1,0,0, 1,0,14'd2,0,0, 0,1,0,0,1,32'hA0000002, 1,0,14'd1));
        vq.push_back(mk("B3", 1,0,14'd1,0,0, 1,0,14'd2,0,0, 1,0,1,32'hA0000001,0,0, 1,0,14'd2));
        vq.push_back(mk("B4", 1,0,14'd1,0,0, 1,0,14'd2,0,0, 0,1,0,0,1,32'hA0000002, 1,0,14'd1));
        vq.push_back(mk("B5", 1,0,14'd1,0,0, 1,0,14'd2,0,0, 1,0,1,32'hA0000001,0,0, 1,0,14'd2));
        vq.push_back(mk("B6", 0,0,14'd1,0,0, 0,0,14'd2,0,0, 0,0,0,0,1,32'hA0000002, 0,0,14'd2));
        run_vecs();
        chk("B.cnt0", 32'(m0_grant_cnt), 32'd3);
        chk("B.cnt1", 32'(m1_grant_cnt), 32'd3);

        // Byte-lane merge through master 1, then out-of-range write and read.
        vq.push_back(mk("C0", 0,0,0,0,0, 0,1,14'd0,4'hF,32'h11223344, 0,0,0,0,0,0, 1,1,14'd0));
        vq.push_back(mk("C1", 0,0,0,0,0, 0,1,14'd0,4'h5,32'hAABBCCDD, 0,0,0,0,0,0, 1,1,14'd0));
        vq.push_back(mk("C2", 0,0,0,0,0, 1,0,14'd0,4'hF,0,            0,0,0,0,0,0, 1,0,14'd0));
        vq.push_back(mk("C3", 0,0,0,0,0, 0,0,14'd0,4'hF,0,            0,0,0,0,1,32'h11BB33DD, 0,0,14'd0));
        run_vecs();
        chk("C.oor_before", 32'(oor_err), 32'd0);
        vq.push_back(mk("C4", 0,0,0,0,0, 0,1,14'd10750,4'hF,32'hFFFFFFFF, 0,0,0,0,0,0, 1,0,14'd10750));
        vq.push_back(mk("C5", 0,0,0,0,0, 1,0,14'd16383,4'hF,0,           0,0,0,0,0,0, 1,0,14'd16383));
        vq.push_back(mk("C6", 0,0,0,0,0, 0,0,14'd16383,4'hF,0,           0,0,0,0,1,32'h0, 0,0,14'd16383));
        vq.push_back(mk("C7", 0,0,0,0,0, 0,0,14'd0,4'hF,0,               0,0,0,0,0,0, 0,0,14'd16383));
        run_vecs();
        chk("C.oor_after", 32'(oor_err), 32'd1);
        chk("C.cnt1", 32'(m1_grant_cnt), 32'd8);
        chk("C.ram10749", ram[10749], 32'hA000_0000 | 32'd10749);

        // Reset arriving the cycle after a read grant discards the pending read.
        @(negedge clk);
        m0_read = 1; m0_address = 14'd1;
        #1 chk("R.grant_wait0", 32'(m0_waitrequest), 32'd0);
        @(negedge clk);
        m0_read = 0; m1_read = 1; m1_address = 14'd4;
        reset_n = 1'b0;
        #1;
        chk("R.wait0", 32'(m0_waitrequest), 32'd1);
        chk("R.wait1", 32'(m1_waitrequest), 32'd1);
        chk("R.rdv0", 32'(m0_readdatavalid), 32'd0);
        chk("R.rd0", m0_readdata, 32'h0);
        chk("R.cs", 32'(mem_chipselect), 32'd0);
        chk("R.we", 32'(mem_write), 32'd0);
        chk("R.clken", 32'(mem_clken), 32'd0);
        chk("R.addr", 32'(mem_address), 32'd0);
        chk("R.cnt0", 32'(m0_grant_cnt), 32'd0);
        chk("R.cnt1", 32'(m1_grant_cnt), 32'd0);
        chk("R.oor", 32'(oor_err), 32'd0);
        repeat (2) @(negedge clk);
        m1_read = 0;
        reset_n = 1'b1;
        #1 chk("R.post_rdv0_a", 32'(m0_readdatavalid), 32'd0);
        @(negedge clk);
        #1 chk("R.post_rdv0_b", 32'(m0_readdatavalid), 32'd0);
        chk("R.post_rdv1", 32'(m1_readdatavalid), 32'd0);

        // Saturation: one master 1 grant, then 65537 consecutive master 0 grants.
        @(negedge clk);
        m1_read = 1; m1_address = 14'd2;
        @(negedge clk);
        m1_read = 0;
        m0_read = 1; m0_address = 14'd6;
        repeat (65537) @(posedge clk);
        @(negedge clk);
        m0_read = 0;
        #1;
        chk("S.cnt0", 32'(m0_grant_cnt), 32'h0000FFFF);
        chk("S.cnt1", 32'(m1_grant_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sopc_onchip_mem_arb.md
SOPC_ONCHIP_MEM_ARB -- requirements
Module: sopc_onchip_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 14: word-address width on both master ports and the memory port.
REQ-002 Parameter DEPTH, default 10750: number of implemented 32-bit words; word addresses >= DEPTH are out of range.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 m0_address  in  ADDR_W  master 0 word address.
REQ-006 m0_byteenable  in  4  master 0 write byte lanes.
REQ-007 m0_read / m0_write  in  1 each  master 0 request strobes, held until accepted.
REQ-008 m0_writedata  in  32  master 0 write data.
REQ-009 m0_waitrequest  out  1  high means the master 0 request is not accepted this cycle.
REQ-010 m0_readdata  out  32; m0_readdatavalid  out  1  master 0 read return.
REQ-011 m1_* ports are identical in name suffix, direction, width and meaning to m0_* (REQ-005..010), for master 1.
REQ-012 mem_address  out  ADDR_W; mem_byteenable  out  4; mem_writedata  out  32  drive the single-port RAM.
REQ-013 mem_chipselect  out  1; mem_write  out  1; mem_clken  out  1  RAM strobes and clock enable.
REQ-014 mem_readdata  in  32  RAM output, valid one clk after the address cycle.
REQ-015 m0_grant_cnt / m1_grant_cnt  out  16 each: accepted-transfer counters.
REQ-016 oor_err  out  1: sticky out-of-range flag.

Function
REQ-017 Request: mX_req = mX_read | mX_write; if both strobes are high, the access is treated as a write and the read is ignored.
REQ-018 Arbitration is per cycle and combinational: only one requester -> grant it; both -> grant the master not recorded in register last_grant.
REQ-019 last_grant (1 bit) SHALL update to the granted master on every grant and hold otherwise.
REQ-020 Granted master: waitrequest=0 in the same cycle; a requesting, non-granted master: waitrequest=1; a non-requesting master: waitrequest=0.
REQ-021 In a grant cycle, mem_address, mem_byteenable and mem_writedata come from the granted master, and mem_chipselect=1; mem_write=1 only for a write to an in-range address.
REQ-022 Idle cycle: mem_chipselect=0, mem_write=0, mem_address holds its last value; mem_clken=1 whenever reset_n=1.
REQ-023 Read latency is fixed at 1: a read accepted in cycle N produces mX_readdatavalid=1 for that master only in cycle N+1, with mX_readdata=mem_readdata.
REQ-024 A registered tag (valid bit, master id, out-of-range bit) SHALL track the pending read; back-to-back reads, including alternating masters, sustain one read per cycle.
REQ-025 An out-of-range read returns readdata=32'h0 with readdatavalid asserted at N+1; an out-of-range write is dropped; both set oor_err, which clears only on reset.
REQ-026 mX_readdata SHALL be 0 whenever mX_readdatavalid=0.
REQ-027 mX_grant_cnt increments by 1 per accepted transfer and saturates at 16'hFFFF.

Reset
REQ-028 While reset_n=0: both waitrequest=1, readdatavalid=0, readdata=0, mem_chipselect=0, mem_write=0, mem_clken=0, mem_address=0, counters=0, oor_err=0, last_grant=1 (master 0 wins the first contention).
REQ-029 An assertion of reset during an outstanding read discards it; no readdatavalid is produced after reset_n returns high.

Verification
REQ-030 Single write then read: m0 writes 32'hDEADBEEF, be=4'hF to addr 5; m0 reads addr 5 -> waitrequest=0 both cycles; m0_readdatavalid one cycle later with 32'hDEADBEEF; m0_grant_cnt=2.
REQ-031 Contention: m0 and m1 both read continuously for 6 cycles after reset -> grants m0,m1,m0,m1,m0,m1; each loser sees waitrequest=1; each readdatavalid goes to the correct master only.
REQ-032 Byte lanes: write 32'h11223344 then 32'hAABBCCDD with be=4'b0101 to addr 0 -> read returns 32'h11BB33DD.
REQ-033 Out of range: m1 writes to addr 10750, then reads addr 16383 -> no mem_write; readdata=0 with readdatavalid; oor_err=1 until reset.
REQ-034 Reset mid-read: assert reset_n=0 in the cycle after a read grant -> no readdatavalid; all outputs at their REQ-028 values; counters=0.
REQ-035 Saturation: force 65537 m0 grants -> m0_grant_cnt=16'hFFFF, m1_grant_cnt unchanged.
